// File: rtl/seq_checker_if.sv
// ============================================================================
// seq_checker_if : strobe/data/status bundle between a sequence source and
//                  the seq_checker receive-side checker.
// Revision 1.0
// ============================================================================
`default_nettype none

interface seq_checker_if #(
  parameter int WIDTH = 8
);
  logic             sample_en;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [WIDTH-1:0] err_count;
  logic [WIDTH-1:0] expected;
  logic [1:0]       state;

  modport master (
    output sample_en, data_in, clr_err,
    input  locked, err_pulse, err_count, expected, state
  );

  modport slave (
    input  sample_en, data_in, clr_err,
    output locked, err_pulse, err_count, expected, state
  );
endinterface

`default_nettype wire

// File: rtl/seq_checker.sv
// ============================================================================
// seq_checker : locks onto a modulo-2^WIDTH incrementing stream and counts
//               out-of-sequence words while locked.
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  seq_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  localparam logic [1:0]    c_SEARCH  = 2'b00;
  localparam logic [1:0]    c_ACQUIRE = 2'b01;
  localparam logic [1:0]    c_LOCKED  = 2'b10;
  localparam logic [MW-1:0] c_LOCK_N  = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] c_LOSS_N  = LW'(LOSS_COUNT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             err_pulse_q, err_pulse_d;
  logic [WIDTH-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] w_expected;
  logic             w_match;
  logic [MW-1:0]    w_match_inc;
  logic [LW-1:0]    w_miss_inc;

  assign w_expected  = prev_q + WIDTH'(1);
  assign w_match     = (bus.data_in == w_expected);
  assign w_match_inc = match_q + MW'(1);
  assign w_miss_inc  = miss_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (bus.sample_en) begin
      case (state_q)
        c_SEARCH: begin
          prev_d  = bus.data_in;
          match_d = '0;
          state_d = c_ACQUIRE;
        end
        c_ACQUIRE: begin
          prev_d = bus.data_in;
          if (w_match) begin
            match_d = w_match_inc;
            if (w_match_inc == c_LOCK_N) begin
              state_d = c_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        c_LOCKED: begin
          if (w_match) begin
            prev_d = bus.data_in;
            miss_d = '0;
          end else begin
            // Flywheel: advance the prediction so one bad word costs one error.
            prev_d      = w_expected;
            err_pulse_d = 1'b1;
            miss_d      = w_miss_inc;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + WIDTH'(1);
            end
            if (w_miss_inc == c_LOSS_N) begin
              state_d = c_SEARCH;
              match_d = '0;
              miss_d  = '0;
            end
          end
        end
        default: begin
          state_d = c_SEARCH;
        end
      endcase
    end

    if (bus.clr_err) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= c_SEARCH;
      prev_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.locked    = (state_q == c_LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = w_expected;

endmodule

`default_nettype wire

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the free-running incrementing byte stream produced by the tile's counter outputs. It samples an 8-bit word whenever a strobe is asserted and locks onto a modulo-2^WIDTH incrementing sequence. Once locked it flags and counts every out-of-sequence word, and drops lock after repeated misses. It sits on the input side of a tile (fed from `ui_in`/`uio_in`) as the loopback/self-test partner of the counter.

## Interface
- `WIDTH`, 8: data and error-counter width.
- `LOCK_COUNT`, 4: consecutive in-sequence samples needed to declare lock (≥1).
- `LOSS_COUNT`, 3: consecutive out-of-sequence samples in LOCKED that drop lock (≥1).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sample_en`  in  1  `data_in` is valid this cycle.
- `data_in`  in  WIDTH  observed sequence word.
- `clr_err`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle strobe per mismatched sample while LOCKED.
- `err_count`  out  WIDTH  saturating count of mismatches while LOCKED.
- `expected`  out  WIDTH  next predicted word (`prev` + 1 mod 2^WIDTH).
- `state`  out  2  00 SEARCH, 01 ACQUIRE, 10 LOCKED.

## Operation
- Internal registers:
  - `prev` (WIDTH): last accepted word.
  - `match_cnt`: sized for `LOCK_COUNT`.
  - `miss_cnt`: sized for `LOSS_COUNT`.
  - `state`.
- `expected` = `prev` + 1, truncated to WIDTH. Wrap-around counts as a match: `prev`=FF, `data_in`=00 → match.
- Cycles with `sample_en`=0: all state is held and `err_pulse` is 0.
- **SEARCH**, on sample: `prev`←`data_in`, `match_cnt`←0, go to ACQUIRE.
- **ACQUIRE**, on sample: `prev`←`data_in`.
  - Match: `match_cnt`++. If the new value equals `LOCK_COUNT`, go to LOCKED with `miss_cnt`←0.
  - Mismatch: `match_cnt`←0 and stay in ACQUIRE. No error is counted.
- **LOCKED**, on sample:
  - Match: `prev`←`data_in`, `miss_cnt`←0.
  - Mismatch: `prev`←`expected` (flywheel: prediction advances, so a single corrupted word gives exactly one error), `err_pulse`←1, `err_count`←min(`err_count`+1, 2^WIDTH−1), `miss_cnt`++.
  - If the new `miss_cnt` equals `LOSS_COUNT`, go to SEARCH with `match_cnt`←0 and `miss_cnt`←0.
- `err_count` behaviour:
  - Saturates at all-ones and never wraps.
  - Holds its value across loss and reacquire of lock.
  - Is cleared only by reset or `clr_err`.
- `clr_err` coincident with a counted mismatch: clear wins, `err_count`=0. `err_pulse` still fires.
- Reset (`rst_n`=0 at a clock edge) takes priority over everything, including mid-acquire and mid-lock. The sample on that edge is discarded.

## Timing
- All outputs are registered. Every update occurs at the rising edge where `sample_en`=1 is sampled, and is visible immediately after that edge.
- Reset values: `state`=SEARCH, `locked`=0, `err_pulse`=0, `err_count`=0, `prev`=0 (so `expected`=01), counters 0.
- Lock latency: `locked` rises at the edge of the (1+`LOCK_COUNT`)-th consecutive in-sequence sample. That is the 5th sample with defaults.
- Loss latency: `locked` falls at the edge of the `LOSS_COUNT`-th consecutive mismatch.
- `err_pulse` width: exactly one clock per mismatched sample. Back-to-back mismatched samples give back-to-back high cycles.
- Gaps in `sample_en` do not affect prediction: the sequence is tracked per sample, not per clock.
- No combinational path from inputs to outputs.

## Test plan
- **Reset then acquire.** Samples 10,11,12,13,14 on consecutive cycles → `state` goes 01 after 10, 10 after 14. `locked`=1 after the 5th edge. `expected`=15, `err_count`=0.
- **Wrap and gapped strobe.** Lock on FB,FC,FD,FE,FF. Then feed 00, idle 3 cycles, 01 → stays locked, `err_pulse` never high, `expected`=02.
- **Single glitch while locked.** Locked with `expected`=20. Feed 20,99,22,23 → one `err_pulse` on the 99 edge, `err_count`=1, `locked` stays 1, `expected`=24 at end.
- **Loss of lock.** Locked with `expected`=30. Feed 00,00,00 → `err_pulse` high 3 consecutive cycles, `err_count`+3. `locked`=0 and `state`=00 after the 3rd edge. Then 40..44 relocks, and `err_count` is unchanged during reacquire.
- **Saturation and clear.** Force 300 mismatches via repeated lock/loss cycles → `err_count` stops at FF. Assert `clr_err` coincident with a mismatch → `err_count`=00 next cycle, `err_pulse`=1.
- **Reset mid-operation.** Locked with `err_count`=5. Assert `rst_n`=0 for 1 edge with `sample_en`=1 → all outputs at reset values. The next 5 in-sequence samples are required to relock.
